// File: rtl/mvm_arb_pkg.sv
// Shared types and helpers for the mvm stream arbiter.
// Holds the arbiter FSM state type and the index-width helper.
package mvm_arb_pkg;

    localparam int AXIS_DATA_W = 512;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_tag_fifo.sv
// In-order FIFO of requester indices, one entry per packet outstanding in mvm.
// Push and pop in the same cycle keep the count; pointers wrap modulo DEPTH.
module mvm_tag_fifo
    import mvm_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    output logic [W-1:0]     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = idx_w(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Gating here only protects the storage; the arbiter never pushes when full.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mvm_stream_arbiter.sv
// Round-robin packet arbiter sharing one mvm engine; results are steered back by tag FIFO.
// Define MVM_ARB_STATS_EN to build the saturating per-requester grant counters.
module mvm_stream_arbiter
    import mvm_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = AXIS_DATA_W,
    parameter int TUSER_W   = 32,
    parameter int TDEST_W   = 8,
    parameter int TID_W     = 8,
    parameter int TAG_DEPTH = 4,
    parameter int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    output logic [NUM_REQ-1:0]            req_tready,
    input  logic [NUM_REQ-1:0]            req_tlast,
    input  logic [NUM_REQ*DATA_W-1:0]     req_tdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_tkeep,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_tstrb,
    input  logic [NUM_REQ*TUSER_W-1:0]    req_tuser,
    input  logic [NUM_REQ*TDEST_W-1:0]    req_tdest,
    output logic                          mvm_rx_tvalid,
    input  logic                          mvm_rx_tready,
    output logic [DATA_W-1:0]             mvm_rx_tdata,
    output logic [DATA_W/8-1:0]           mvm_rx_tkeep,
    output logic [DATA_W/8-1:0]           mvm_rx_tstrb,
    output logic [TID_W-1:0]              mvm_rx_tid,
    output logic [TDEST_W-1:0]            mvm_rx_tdest,
    output logic [TUSER_W-1:0]            mvm_rx_tuser,
    output logic                          mvm_rx_tlast,
    input  logic                          mvm_tx_tvalid,
    output logic                          mvm_tx_tready,
    input  logic [DATA_W-1:0]             mvm_tx_tdata,
    input  logic [DATA_W/8-1:0]           mvm_tx_tkeep,
    input  logic [DATA_W/8-1:0]           mvm_tx_tstrb,
    input  logic [TID_W-1:0]              mvm_tx_tid,
    input  logic [TDEST_W-1:0]            mvm_tx_tdest,
    input  logic [TUSER_W-1:0]            mvm_tx_tuser,
    input  logic                          mvm_tx_tlast,
    output logic [NUM_REQ-1:0]            rsp_tvalid,
    input  logic [NUM_REQ-1:0]            rsp_tready,
    output logic [NUM_REQ-1:0]            rsp_tlast,
    output logic [DATA_W-1:0]             rsp_tdata,
    output logic [DATA_W/8-1:0]           rsp_tkeep,
    output logic [TUSER_W-1:0]            rsp_tuser,
    output logic                          rsp_err,
    output logic [NUM_REQ*16-1:0]         stat_pkts,
    output logic                          dbg_state,
    output logic [CNT_W-1:0]              dbg_tag_count
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int KW    = DATA_W / 8;

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_rsp_err;

    logic             w_rr_found;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W:0]   w_sum;
    logic             w_grant_fire;
    logic             w_rx_last_hs;
    logic [IDX_W-1:0] w_head;
    logic             w_tag_full;
    logic             w_tag_empty;
    logic             w_tag_pop;
    logic             w_unused;

    // Search from r_rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_rr_ptr;
        w_sum      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_rr_found && req_tvalid[w_sum[IDX_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_grant_fire = (r_state == IDLE) && w_rr_found && !w_tag_full;
    assign w_rx_last_hs = (r_state == BUSY) && req_tvalid[r_grant] && mvm_rx_tready
                          && req_tlast[r_grant];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_fire) begin
                        r_grant <= w_rr_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_rx_last_hs) begin
                        r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_tready    = '0;
        mvm_rx_tvalid = 1'b0;
        mvm_rx_tid    = '0;
        mvm_rx_tid[IDX_W-1:0] = r_grant;
        if (r_state == BUSY) begin
            mvm_rx_tvalid       = req_tvalid[r_grant];
            req_tready[r_grant] = mvm_rx_tready;
        end
    end

    assign mvm_rx_tdata = req_tdata[r_grant*DATA_W +: DATA_W];
    assign mvm_rx_tkeep = req_tkeep[r_grant*KW +: KW];
    assign mvm_rx_tstrb = req_tstrb[r_grant*KW +: KW];
    assign mvm_rx_tuser = req_tuser[r_grant*TUSER_W +: TUSER_W];
    assign mvm_rx_tdest = req_tdest[r_grant*TDEST_W +: TDEST_W];
    assign mvm_rx_tlast = req_tlast[r_grant];

    mvm_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDX_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_last_hs),
        .i_din   (r_grant),
        .i_pop   (w_tag_pop),
        .o_head  (w_head),
        .o_count (dbg_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    // With no owner on record the result is held off rather than dropped.
    always_comb begin
        rsp_tvalid    = '0;
        rsp_tlast     = '0;
        mvm_tx_tready = 1'b0;
        if (!w_tag_empty) begin
            rsp_tvalid[w_head] = mvm_tx_tvalid;
            rsp_tlast[w_head]  = mvm_tx_tlast;
            mvm_tx_tready      = rsp_tready[w_head];
        end
    end

    assign w_tag_pop = mvm_tx_tvalid && mvm_tx_tready && mvm_tx_tlast;
    assign rsp_tdata = mvm_tx_tdata;
    assign rsp_tkeep = mvm_tx_tkeep;
    assign rsp_tuser = mvm_tx_tuser;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_err <= 1'b0;
        end else if (mvm_tx_tvalid && w_tag_empty) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;
    assign w_unused  = ^{mvm_tx_tstrb, mvm_tx_tid, mvm_tx_tdest};

`ifdef MVM_ARB_STATS_EN
    logic [15:0] r_stat [NUM_REQ];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_grant_fire && (r_stat[w_rr_idx] != 16'hFFFF)) begin
            r_stat[w_rr_idx] <= r_stat[w_rr_idx] + 16'd1;
        end
    end

    always_comb begin
        stat_pkts = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_pkts[i*16 +: 16] = r_stat[i];
        end
    end
`else
    assign stat_pkts = '0;
`endif

endmodule

// File: tb/tb_mvm_stream_arbiter.sv
// Directed bench for mvm_stream_arbiter: grant order, steering, full gating, orphans, backpressure.
module tb_mvm_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 512;
    localparam int KW  = DW / 8;
    localparam int UW  = 32;
    localparam int DTW = 8;
    localparam int TW  = 8;
    localparam int CW  = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_tvalid, req_tready, req_tlast;
    logic [N*DW-1:0] req_tdata;
    logic [N*KW-1:0] req_tkeep, req_tstrb;
    logic [N*UW-1:0] req_tuser;
    logic [N*DTW-1:0] req_tdest;
    logic            mvm_rx_tvalid, mvm_rx_tready, mvm_rx_tlast;
    logic [DW-1:0]   mvm_rx_tdata;
    logic [KW-1:0]   mvm_rx_tkeep, mvm_rx_tstrb;
    logic [TW-1:0]   mvm_rx_tid;
    logic [DTW-1:0]  mvm_rx_tdest;
    logic [UW-1:0]   mvm_rx_tuser;
    logic            mvm_tx_tvalid, mvm_tx_tready, mvm_tx_tlast;
    logic [DW-1:0]   mvm_tx_tdata;
    logic [KW-1:0]   mvm_tx_tkeep, mvm_tx_tstrb;
    logic [TW-1:0]   mvm_tx_tid;
    logic [DTW-1:0]  mvm_tx_tdest;
    logic [UW-1:0]   mvm_tx_tuser;
    logic [N-1:0]    rsp_tvalid, rsp_tready, rsp_tlast;
    logic [DW-1:0]   rsp_tdata;
    logic [KW-1:0]   rsp_tkeep;
    logic [UW-1:0]   rsp_tuser;
    logic            rsp_err;
    logic [N*16-1:0] stat_pkts;
    logic            dbg_state;
    logic [CW-1:0]   dbg_tag_count;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] exp_q[$];

    mvm_stream_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .TUSER_W(UW), .TDEST_W(DTW), .TID_W(TW), .TAG_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
        .req_tdata(req_tdata), .req_tkeep(req_tkeep), .req_tstrb(req_tstrb),
        .req_tuser(req_tuser), .req_tdest(req_tdest),
        .mvm_rx_tvalid(mvm_rx_tvalid), .mvm_rx_tready(mvm_rx_tready),
        .mvm_rx_tdata(mvm_rx_tdata), .mvm_rx_tkeep(mvm_rx_tkeep), .mvm_rx_tstrb(mvm_rx_tstrb),
        .mvm_rx_tid(mvm_rx_tid), .mvm_rx_tdest(mvm_rx_tdest), .mvm_rx_tuser(mvm_rx_tuser),
        .mvm_rx_tlast(mvm_rx_tlast),
        .mvm_tx_tvalid(mvm_tx_tvalid), .mvm_tx_tready(mvm_tx_tready),
        .mvm_tx_tdata(mvm_tx_tdata), .mvm_tx_tkeep(mvm_tx_tkeep), .mvm_tx_tstrb(mvm_tx_tstrb),
        .mvm_tx_tid(mvm_tx_tid), .mvm_tx_tdest(mvm_tx_tdest), .mvm_tx_tuser(mvm_tx_tuser),
        .mvm_tx_tlast(mvm_tx_tlast),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tlast(rsp_tlast),
        .rsp_tdata(rsp_tdata), .rsp_tkeep(rsp_tkeep), .rsp_tuser(rsp_tuser),
        .rsp_err(rsp_err), .stat_pkts(stat_pkts),
        .dbg_state(dbg_state), .dbg_tag_count(dbg_tag_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        req_tvalid    = '0;
        req_tlast     = '0;
        mvm_tx_tvalid = 1'b0;
        mvm_tx_tlast  = 1'b0;
        rsp_tready    = '1;
        mvm_rx_tready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_rx_tvalid", 64'(mvm_rx_tvalid), 64'd0);
        check("rst_req_tready", 64'(req_tready), 64'd0);
        check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        check("rst_tx_tready", 64'(mvm_tx_tready), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_count", 64'(dbg_tag_count), 64'd0);
        check("rst_stats", stat_pkts[63:0], 64'd0);
        rst = 1'b1;
        step();
    endtask

    // Driver tasks
    task automatic set_req_data(input int idx, input logic [7:0] b);
        req_tdata[idx*DW +: DW] = {KW{b}};
    endtask

    task automatic send_pkt1(input int idx);
        bit done;
        done = 1'b0;
        req_tvalid[idx] = 1'b1;
        req_tlast[idx]  = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (req_tready[idx]) done = 1'b1;
            step();
        end
        req_tvalid[idx] = 1'b0;
        req_tlast[idx]  = 1'b0;
        check("pkt_accept", 64'(done), 64'd1);
    endtask

    task automatic send_rsp1(input logic [7:0] b);
        bit done;
        done = 1'b0;
        mvm_tx_tvalid = 1'b1;
        mvm_tx_tlast  = 1'b1;
        mvm_tx_tdata  = {KW{b}};
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (mvm_tx_tready) done = 1'b1;
            step();
        end
        mvm_tx_tvalid = 1'b0;
        mvm_tx_tlast  = 1'b0;
        check("rsp_accept", 64'(done), 64'd1);
    endtask

    logic [N-1:0] hs;
    logic [7:0]   rsp_bytes [5];

    initial begin
        req_tdata    = '0;
        req_tkeep    = '1;
        req_tstrb    = '1;
        req_tuser    = '0;
        req_tdest    = '0;
        mvm_tx_tdata = '0;
        mvm_tx_tkeep = '1;
        mvm_tx_tstrb = '1;
        mvm_tx_tid   = '0;
        mvm_tx_tdest = '0;
        mvm_tx_tuser = '0;
        do_reset();

        // Requester 2, two-beat packet
        req_tvalid[2] = 1'b1;
        set_req_data(2, 8'hA5);
        @(negedge clk);
        check("t1_idle_rx", 64'(mvm_rx_tvalid), 64'd0);
        step();
        @(negedge clk);
        check("t1_b0_valid", 64'(mvm_rx_tvalid), 64'd1);
        check("t1_b0_tid", 64'(mvm_rx_tid), 64'd2);
        check("t1_b0_data", mvm_rx_tdata[63:0], {8{8'hA5}});
        check("t1_b0_ready", 64'(req_tready), 64'b0100);
        step();
        req_tlast[2] = 1'b1;
        set_req_data(2, 8'h5A);
        @(negedge clk);
        check("t1_b1_valid", 64'(mvm_rx_tvalid), 64'd1);
        check("t1_b1_last", 64'(mvm_rx_tlast), 64'd1);
        check("t1_b1_data", mvm_rx_tdata[63:0], {8{8'h5A}});
        step();
        req_tvalid[2] = 1'b0;
        req_tlast[2]  = 1'b0;
        @(negedge clk);
        check("t1_gap_rx", 64'(mvm_rx_tvalid), 64'd0);
        check("t1_count", 64'(dbg_tag_count), 64'd1);
        check("t1_state", 64'(dbg_state), 64'd0);
        mvm_tx_tvalid = 1'b1;
        mvm_tx_tlast  = 1'b1;
        mvm_tx_tdata  = {KW{8'hC3}};
        #1;
        check("t1_rsp_valid", 64'(rsp_tvalid), 64'b0100);
        check("t1_tx_ready", 64'(mvm_tx_tready), 64'd1);
        check("t1_rsp_data", rsp_tdata[63:0], {8{8'hC3}});
        step();
        mvm_tx_tvalid = 1'b0;
        mvm_tx_tlast  = 1'b0;
        @(negedge clk);
        check("t1_count_pop", 64'(dbg_tag_count), 64'd0);
        step();

        // All four requesters at once from reset: 0,1,2,3 with a gap after each
        do_reset();
        req_tvalid = '1;
        req_tlast  = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_rx_valid", 64'(mvm_rx_tvalid), 64'(k % 2));
            if (k % 2 == 1) check("t2_rx_tid", 64'(mvm_rx_tid), 64'(k / 2));
            hs = req_tready & req_tvalid;
            step();
            req_tvalid = req_tvalid & ~hs;
        end
        req_tvalid = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t2_full_count", 64'(dbg_tag_count), 64'd4);
            check("t2_full_ready", 64'(req_tready), 64'd0);
            check("t2_full_rx", 64'(mvm_rx_tvalid), 64'd0);
            step();
        end
        mvm_tx_tvalid = 1'b1;
        mvm_tx_tlast  = 1'b1;
        mvm_tx_tdata  = {KW{8'h00}};
        @(negedge clk);
        check("t2_pop_rsp", 64'(rsp_tvalid), 64'b0001);
        check("t2_pop_txr", 64'(mvm_tx_tready), 64'd1);
        step();
        mvm_tx_tvalid = 1'b0;
        @(negedge clk);
        check("t2_post_pop_rx", 64'(mvm_rx_tvalid), 64'd0);
        step();
        @(negedge clk);
        check("t2_regrant_valid", 64'(mvm_rx_tvalid), 64'd1);
        check("t2_regrant_tid", 64'(mvm_rx_tid), 64'd1);
        check("t2_regrant_ready", 64'(req_tready), 64'b0010);
        step();
        req_tvalid[1] = 1'b0;
        @(negedge clk);
        check("t2_refull_count", 64'(dbg_tag_count), 64'd4);
        step();

        // Results return in issue order: owners 1,2,3,1 then the newly granted 3
        exp_q = {64'b0010, 64'b0100, 64'b1000, 64'b0010, 64'b1000};
        rsp_bytes = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h33};
        mvm_tx_tvalid = 1'b1;
        mvm_tx_tlast  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mvm_tx_tdata = {KW{rsp_bytes[k]}};
            @(negedge clk);
            check("t3_rsp_valid", 64'(rsp_tvalid), exp_q.pop_front());
            check("t3_rsp_data", rsp_tdata[63:0], {8{rsp_bytes[k]}});
            check("t3_tx_ready", 64'(mvm_tx_tready), 64'd1);
            if (k == 1) check("t3_rx_gap", 64'(mvm_rx_tvalid), 64'd0);
            if (k == 2) check("t3_rx_tid3", 64'(mvm_rx_tid), 64'd3);
            if (k == 2) check("t3_rx_valid3", 64'(mvm_rx_tvalid), 64'd1);
            step();
            if (k == 2) req_tvalid[3] = 1'b0;
        end
        mvm_tx_tvalid = 1'b0;
        @(negedge clk);
        check("t3_drained", 64'(dbg_tag_count), 64'd0);
        req_tlast = '0;
        step();

        // Orphan response
        mvm_tx_tvalid = 1'b1;
        mvm_tx_tlast  = 1'b1;
        @(negedge clk);
        check("orph_tx_ready", 64'(mvm_tx_tready), 64'd0);
        check("orph_rsp_valid", 64'(rsp_tvalid), 64'd0);
        step();
        @(negedge clk);
        check("orph_err_set", 64'(rsp_err), 64'd1);
        check("orph_tx_ready2", 64'(mvm_tx_tready), 64'd0);
        step();
        mvm_tx_tvalid = 1'b0;
        mvm_tx_tlast  = 1'b0;

        // Response backpressure on the owner for three cycles
        send_pkt1(0);
        mvm_tx_tvalid = 1'b1;
        mvm_tx_tlast  = 1'b0;
        mvm_tx_tdata  = {KW{8'h01}};
        rsp_tready    = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_tx_ready", 64'(mvm_tx_tready), 64'd0);
            check("bp_rsp_valid", 64'(rsp_tvalid), 64'b0001);
            step();
        end
        rsp_tready = '1;
        @(negedge clk);
        check("bp_b0_ready", 64'(mvm_tx_tready), 64'd1);
        check("bp_b0_data", rsp_tdata[63:0], {8{8'h01}});
        step();
        mvm_tx_tlast = 1'b1;
        mvm_tx_tdata = {KW{8'h02}};
        @(negedge clk);
        check("bp_b1_ready", 64'(mvm_tx_tready), 64'd1);
        check("bp_b1_last", 64'(rsp_tlast), 64'b0001);
        check("bp_count_before", 64'(dbg_tag_count), 64'd1);
        step();
        mvm_tx_tvalid = 1'b0;
        mvm_tx_tlast  = 1'b0;
        @(negedge clk);
        check("bp_count_after", 64'(dbg_tag_count), 64'd0);
        check("err_sticky", 64'(rsp_err), 64'd1);
        step();

        // Reset clears the sticky error; then five grants to requester 2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_pkt1(2);
            send_rsp1(8'h20 + 8'(k));
        end
        @(negedge clk);
`ifdef MVM_ARB_STATS_EN
        check("stat_req2", 64'(stat_pkts[2*16 +: 16]), 64'd5);
        check("stat_req0", 64'(stat_pkts[0 +: 16]), 64'd0);
`else
        check("stat_off", stat_pkts[63:0], 64'd0);
`endif
        check("final_err", 64'(rsp_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
